// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC-facing fetch address/control and decode-facing instruction word.
interface fetch_stage_if #(
  parameter int IW = 9,
  parameter int AW = 12
);
  logic [AW-1:0] prog_ct;
  logic          branch;
  logic          done;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          halt_req;

  modport master (
    input  prog_ct, branch, done,
    output instr, instr_pc, instr_valid, halt_req
  );

  modport slave (
    output prog_ct, branch, done,
    input  instr, instr_pc, instr_valid, halt_req
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: registered imem read, branch squash, HALT detect,
// program-load port and saturating issue/squash statistics.
module fetch_stage #(
  parameter int            IW      = 9,
  parameter int            AW      = 12,
  parameter int            DEPTH   = 4096,
  parameter logic [IW-1:0] HALT_OP = IW'(9'h1FF),
  parameter logic [IW-1:0] NOP     = IW'(9'h000)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master fif,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  output logic          load_err,
  output logic [15:0]   fetch_count,
  output logic [7:0]    squash_count
);
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {FILL, RUN, HALTED} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          instr_valid_q, instr_valid_d;
  logic          load_err_q, load_err_d;
  logic [15:0]   fetch_count_q, fetch_count_d;
  logic [7:0]    squash_count_q, squash_count_d;

  logic [IW-1:0] mem [DEPTH];
  logic          rd_ok, ld_ok, ld_accept, halt_req;
  logic [IW-1:0] rd_word;

  // Range checks only exist when the array does not cover the full address space.
  generate
    if (DEPTH >= 2**AW) begin : g_full
      assign rd_ok = 1'b1;
      assign ld_ok = 1'b1;
    end else begin : g_part
      assign rd_ok = ({1'b0, fif.prog_ct} < (AW+1)'(DEPTH));
      assign ld_ok = ({1'b0, load_addr}   < (AW+1)'(DEPTH));
    end
  endgenerate

  assign rd_word   = rd_ok ? mem[fif.prog_ct[MW-1:0]] : NOP;
  assign ld_accept = load_en && ld_ok && (reset || state_q == HALTED);

  // Read happens through instr_q on the same edge, so a colliding write is seen next time.
  always_ff @(posedge clk) begin
    if (ld_accept) mem[load_addr[MW-1:0]] <= load_data;
  end

  assign halt_req = (instr_valid_q && instr_q == HALT_OP) || state_q == HALTED;

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    instr_valid_d  = instr_valid_q;
    fetch_count_d  = fetch_count_q;
    squash_count_d = squash_count_q;
    load_err_d     = load_en && !ld_accept;
    case (state_q)
      FILL: begin
        instr_d       = rd_word;
        instr_pc_d    = fif.prog_ct;
        instr_valid_d = 1'b1;
        state_d       = RUN;
      end
      RUN: begin
        if (instr_valid_q && fetch_count_q != 16'hFFFF)
          fetch_count_d = fetch_count_q + 16'd1;
        if (halt_req || fif.done) begin
          state_d       = HALTED;
          instr_d       = NOP;
          instr_valid_d = 1'b0;
        end else begin
          instr_d       = rd_word;
          instr_pc_d    = fif.prog_ct;
          // A branch on a bubble is meaningless; only a live word opens a squash slot.
          instr_valid_d = !(fif.branch && instr_valid_q);
          if (fif.branch && instr_valid_q && squash_count_q != 8'hFF)
            squash_count_d = squash_count_q + 8'd1;
        end
      end
      HALTED: begin
        instr_d       = NOP;
        instr_valid_d = 1'b0;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FILL;
      instr_q        <= NOP;
      instr_pc_q     <= '0;
      instr_valid_q  <= 1'b0;
      load_err_q     <= 1'b0;
      fetch_count_q  <= '0;
      squash_count_q <= '0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      instr_valid_q  <= instr_valid_d;
      load_err_q     <= load_err_d;
      fetch_count_q  <= fetch_count_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign fif.instr       = instr_q;
  assign fif.instr_pc    = instr_pc_q;
  assign fif.instr_valid = instr_valid_q;
  assign fif.halt_req    = halt_req;
  assign load_err        = load_err_q;
  assign fetch_count     = fetch_count_q;
  assign squash_count    = squash_count_q;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly downstream of the program counter. Each cycle it reads the instruction memory at the PC's `prog_ct`, registers the word, and presents it to decode. It also:
- squashes the wrong-path word after a taken branch;
- detects the HALT opcode and drives the PC's `halt` input;
- owns the program-load write port into instruction memory;
- keeps issue statistics.

## Interface
Parameters:
- `IW`, default 9: instruction width.
- `AW`, default 12: address width; it matches `prog_ct`.
- `DEPTH`, default 4096: instruction memory words. `DEPTH` ≤ 2^AW.
- `HALT_OP`, default 9'h1FF: opcode that stops the machine.
- `NOP`, default 9'h000: word driven when no instruction is valid.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `prog_ct`  in  AW: fetch address from the PC.
- `branch`  in  1: taken branch, resolved by decode this cycle for the word currently on `instr`.
- `done`  in  1: PC reports that it has halted.
- `load_en`  in  1: program-load write strobe.
- `load_addr`  in  AW: program-load address.
- `load_data`  in  IW: program-load data.
- `instr`  out  IW: registered instruction to decode.
- `instr_pc`  out  AW: address `instr` was fetched from.
- `instr_valid`  out  1: `instr` is a real, non-squashed instruction.
- `halt_req`  out  1: drives the PC's `halt` input.
- `load_err`  out  1: one-cycle pulse when a load is refused.
- `fetch_count`  out  16: valid instructions issued; saturates at 16'hFFFF.
- `squash_count`  out  8: squashed fetches; saturates at 8'hFF.

## Operation
Memory:
- Single synchronous-read array, `DEPTH` x `IW`.
- Read is read-before-write: a same-cycle load to the fetched address returns the old word.
- Memory contents are not cleared by reset.

State machine: FILL, RUN, HALTED.
- `reset` forces FILL from any state, including mid-run.
- FILL lasts exactly one cycle. It captures `mem[prog_ct]`, then moves to RUN. `instr_valid` = 0 throughout FILL.
- RUN, every edge:
  - `instr` <= `mem[prog_ct]`
  - `instr_pc` <= `prog_ct`
  - `instr_valid` <= !`branch`
- A word captured in a cycle with `branch` = 1 is wrong-path:
  - it is still loaded into `instr`/`instr_pc`;
  - `instr_valid` = 0 for it;
  - `squash_count` increments.
- `branch` is ignored when `instr_valid` = 0. Such a cycle neither squashes nor counts.
- `halt_req` is combinational: `instr_valid` && `instr` == `HALT_OP`, OR state == HALTED.
- RUN -> HALTED on the edge where `halt_req` = 1 or `done` = 1.
- HALTED:
  - `instr_valid` = 0;
  - `instr` = `NOP`;
  - `halt_req` held at 1;
  - counters frozen;
  - exits only through `reset`.
- `fetch_count` increments on every edge at which `instr_valid` = 1, including the HALT word itself.
- Program load:
  - accepted when `reset` = 1 or state == HALTED;
  - otherwise refused: memory is unchanged and `load_err` pulses on the next cycle.
- `load_addr` ≥ `DEPTH` is refused with a `load_err` pulse in every state.
- An out-of-range `prog_ct` (≥ `DEPTH`) reads `NOP` and still issues as valid.

## Timing
Reset values, applied on the edge where `reset` = 1:
- `instr` = `NOP`, `instr_pc` = 0, `instr_valid` = 0, `halt_req` = 0
- `load_err` = 0, `fetch_count` = 0, `squash_count` = 0, state = FILL

Latency and ordering:
- Fetch latency is one cycle: `prog_ct` presented in cycle t appears on `instr` in cycle t+1.
- First valid instruction (address 0) is on `instr` in the second cycle after `reset` deasserts.
- Branch penalty is exactly one bubble: the word fetched in the branch cycle is squashed, and the target word is valid two cycles after `branch`.
- `halt_req` rises in the same cycle the HALT word is valid, so the PC sets `done` at the following edge.
- Simultaneous `branch` and HALT on `instr`: halt wins. The state goes to HALTED, `squash_count` is not incremented and `fetch_count` counts the HALT word.
- `reset` together with `load_en`: the load is accepted and the reset is applied.

## Test plan
- Straight-line fetch: load mem[0..3] = 9'h011, 022, 033, 1FF; release reset; PC counts. Expect:
  - `instr` = 011/022/033 with `instr_pc` = 0/1/2, valid on cycles 2, 3, 4;
  - `halt_req` = 1 on cycle 5;
  - `fetch_count` = 4, then frozen.
- Taken branch: `branch` = 1 while `instr_pc` = 5 (target 12). Expect:
  - next cycle `instr_pc` = 6 with `instr_valid` = 0;
  - then `instr_pc` = 12 valid;
  - `squash_count` = 1.
- Back-to-back branches on two consecutive valid words: the second cycle's branch is ignored because it lands on a squashed word, and `squash_count` = 1.
- Load refused in RUN: `load_en` with `load_addr` = 3. Expect `load_err` pulse the next cycle and mem[3] unchanged. The same load in HALTED succeeds with no pulse.
- Reset mid-run at `fetch_count` = 7. Expect:
  - all outputs at reset values;
  - FILL for one cycle;
  - `instr_pc` = 0 valid afterwards.
- Saturation: force 70000 valid issues; `fetch_count` holds at 16'hFFFF. Likewise 300 squashes hold `squash_count` at 8'hFF.
